// File: rtl/kyber_pkg.sv
// Shared Kyber load-path constants.
// Sizing for the AXI-to-coefficient gearboxes.
package kyber_pkg;

   localparam int KYBER_N      = 256;
   localparam int KYBER_Q_BITS = 12;
   localparam int AXI_DATA_W   = 32;

   localparam int BUF_W  = AXI_DATA_W + KYBER_Q_BITS - 1;
   localparam int FILL_W = $clog2(BUF_W + 1);

endpackage

// File: rtl/frame_counter.sv
// Coefficient position within a frame.
// Wraps to zero on the step that leaves the last position.
module frame_counter #(
   parameter int FRAME_COEFFS = 256,
   localparam int CW = (FRAME_COEFFS > 1) ? $clog2(FRAME_COEFFS) : 1
) (
   input  logic          i_clk,
   input  logic          i_reset_n,
   input  logic          i_step,
   output logic [CW-1:0] o_count,
   output logic          o_last
);

   localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_COEFFS - 1);

   assign o_last = (o_count == LAST_IDX);

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         o_count <= '0;
      end else if (i_step) begin
         if (o_last) o_count <= '0;
         else        o_count <= o_count + 1'b1;
      end
   end

endmodule

// File: rtl/unpack_gearbox.sv
// Splits wide input words into narrow coefficients, LSB first.
// Frames end after FRAME_COEFFS coefficients; residual bits are dropped.
module unpack_gearbox
   import kyber_pkg::*;
#(
   parameter int INPUT_WIDTH  = AXI_DATA_W,
   parameter int OUTPUT_WIDTH = KYBER_Q_BITS,
   parameter int FRAME_COEFFS = KYBER_N
) (
   input  logic                    i_clk,
   input  logic                    i_reset_n,
   input  logic [INPUT_WIDTH-1:0]  i_data,
   input  logic                    i_data_valid,
   output logic                    o_data_ready,
   output logic [OUTPUT_WIDTH-1:0] o_coeff,
   output logic                    o_coeff_valid,
   input  logic                    i_coeff_ready,
   output logic                    o_coeff_last
);

   localparam int BW = INPUT_WIDTH + OUTPUT_WIDTH - 1;
   localparam int FW = $clog2(BW + 1);
   localparam int CW = (FRAME_COEFFS > 1) ? $clog2(FRAME_COEFFS) : 1;

   localparam logic [FW-1:0] OW_F = FW'(OUTPUT_WIDTH);
   localparam logic [FW-1:0] IW_F = FW'(INPUT_WIDTH);
   localparam logic [BW-1:0] WMASK = BW'({INPUT_WIDTH{1'b1}});

   logic [BW-1:0] bits_q;
   logic [FW-1:0] fill;
   logic [CW-1:0] cnt;
   logic          cnt_last;
   logic          accept;
   logic          emit;
   logic [BW-1:0] word_sh;
   logic [BW-1:0] mask_sh;

   assign o_data_ready  = i_reset_n && (fill < OW_F);
   assign o_coeff_valid = (fill >= OW_F);
   assign o_coeff       = bits_q[OUTPUT_WIDTH-1:0];
   assign o_coeff_last  = o_coeff_valid && cnt_last;

   assign accept = i_data_valid && o_data_ready;
   assign emit   = o_coeff_valid && i_coeff_ready;

   // Place the new word directly above the bits still held.
   assign word_sh = BW'(i_data) << fill;
   assign mask_sh = WMASK << fill;

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         bits_q <= '0;
         fill   <= '0;
      end else if (emit && o_coeff_last) begin
         bits_q <= '0;
         fill   <= '0;
      end else if (emit) begin
         bits_q <= bits_q >> OUTPUT_WIDTH;
         fill   <= fill - OW_F;
      end else if (accept) begin
         bits_q <= (bits_q & ~mask_sh) | word_sh;
         fill   <= fill + IW_F;
      end
   end

   frame_counter #(
      .FRAME_COEFFS(FRAME_COEFFS)
   ) u_cnt (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_step    (emit),
      .o_count   (cnt),
      .o_last    (cnt_last)
   );

endmodule

// File: tb/tb_unpack_gearbox.sv
// Scoreboard bench for unpack_gearbox (32 -> 12, 256 per frame).
// A bit-queue model predicts each coefficient at word acceptance.
module tb_unpack_gearbox;

   localparam int IW = 32;
   localparam int OW = 12;
   localparam int FN = 256;

   logic          i_clk = 1'b0;
   logic          i_reset_n = 1'b0;
   logic [IW-1:0] i_data = '0;
   logic          i_data_valid = 1'b0;
   logic          o_data_ready;
   logic [OW-1:0] o_coeff;
   logic          o_coeff_valid;
   logic          i_coeff_ready = 1'b0;
   logic          o_coeff_last;

   int errors = 0;
   int checks = 0;

   bit            mq[$];
   logic [OW:0]   eq[$];
   int            mcnt = 0;
   int            acc_cnt = 0;
   int            emit_cnt = 0;
   int            last_cnt = 0;
   int            last_at = 0;

   always #5 i_clk = ~i_clk;

   unpack_gearbox dut (
      .i_clk         (i_clk),
      .i_reset_n     (i_reset_n),
      .i_data        (i_data),
      .i_data_valid  (i_data_valid),
      .o_data_ready  (o_data_ready),
      .o_coeff       (o_coeff),
      .o_coeff_valid (o_coeff_valid),
      .i_coeff_ready (i_coeff_ready),
      .o_coeff_last  (o_coeff_last)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // Handshakes are observed mid-cycle, ahead of the edge that commits them.
   always @(negedge i_clk) begin
      if (!i_reset_n) begin
         mq.delete();
         eq.delete();
         mcnt = 0;
      end else begin
         if (i_data_valid && o_data_ready) begin
            acc_cnt++;
            for (int b = 0; b < IW; b++) mq.push_back(i_data[b]);
            while (mq.size() >= OW) begin
               logic [OW-1:0] c;
               logic          l;
               for (int k = 0; k < OW; k++) c[k] = mq.pop_front();
               l = (mcnt == FN - 1);
               eq.push_back({l, c});
               if (l) begin
                  mcnt = 0;
                  mq.delete();
               end else begin
                  mcnt++;
               end
            end
         end
         if (o_coeff_valid && i_coeff_ready) begin
            emit_cnt++;
            if (o_coeff_last) begin
               last_cnt++;
               last_at = emit_cnt;
            end
            if (eq.size() == 0) begin
               check("extra_coeff", 32'(o_coeff), 32'hFFFF_FFFF);
            end else begin
               logic [OW:0] e;
               e = eq.pop_front();
               check("coeff", 32'(o_coeff), 32'(e[OW-1:0]));
               check("last", 32'(o_coeff_last), 32'(e[OW]));
            end
         end
      end
   end

   task automatic do_reset();
      i_reset_n    = 1'b0;
      i_data_valid = 1'b0;
      i_coeff_ready = 1'b0;
      @(negedge i_clk);
      check("rst_ready_low", 32'(o_data_ready), 32'd0);
      @(posedge i_clk);
      #1;
      check("rst_valid", 32'(o_coeff_valid), 32'd0);
      check("rst_last", 32'(o_coeff_last), 32'd0);
      i_reset_n = 1'b1;
      @(negedge i_clk);
      check("rel_ready", 32'(o_data_ready), 32'd1);
      check("rel_coeff", 32'(o_coeff), 32'd0);
      @(posedge i_clk);
      #1;
      emit_cnt = 0;
      last_cnt = 0;
      last_at  = 0;
      acc_cnt  = 0;
   endtask

   task automatic send(input int n, input logic [31:0] base, input bit rnd);
      for (int i = 0; i < n; i++) begin
         bit got;
         int g;
         got = 1'b0;
         g   = 0;
         i_data       = base + 32'(i);
         i_data_valid = 1'b1;
         while (!got && g < 200) begin
            @(negedge i_clk);
            got = o_data_ready;
            @(posedge i_clk);
            #1;
            i_coeff_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            g++;
         end
         if (!got) check("send_timeout", 32'(i), 32'hFFFF_FFFF);
      end
      i_data_valid = 1'b0;
   endtask

   task automatic drain(input bit rnd);
      int g;
      g = 0;
      while ((eq.size() != 0 || o_coeff_valid) && g < 3000) begin
         @(posedge i_clk);
         #1;
         i_coeff_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         g++;
      end
      check("drain_done", 32'(eq.size()), 32'd0);
      i_coeff_ready = 1'b1;
   endtask

   initial begin
      logic [OW-1:0] held;
      int            acc0;
      int            g;

      repeat (2) @(posedge i_clk);
      #1;
      do_reset();
      repeat (3) @(posedge i_clk);
      #1;
      check("idle_valid", 32'(o_coeff_valid), 32'd0);
      check("idle_ready", 32'(o_data_ready), 32'd1);
      check("idle_coeff", 32'(o_coeff), 32'd0);

      // Directed: two words, downstream always ready.
      i_coeff_ready = 1'b1;
      send(1, 32'h7654_3210, 1'b0);
      send(1, 32'hFEDC_BA98, 1'b0);
      drain(1'b0);
      @(negedge i_clk);
      check("dir_count", 32'(emit_cnt), 32'd5);
      check("dir_fill", 32'(dut.fill), 32'd4);
      check("dir_ready", 32'(o_data_ready), 32'd1);
      check("dir_valid", 32'(o_coeff_valid), 32'd0);

      // Full frame with random downstream stalls.
      do_reset();
      send(96, 32'h0000_1000, 1'b1);
      drain(1'b1);
      @(negedge i_clk);
      check("frm_count", 32'(emit_cnt), 32'd256);
      check("frm_lasts", 32'(last_cnt), 32'd1);
      check("frm_last_at", 32'(last_at), 32'd256);
      check("frm_fill", 32'(dut.fill), 32'd0);
      check("frm_cnt", 32'(dut.cnt), 32'd0);

      // Backpressure hold.
      do_reset();
      send(1, 32'hA5A5_5A5A, 1'b0);
      i_coeff_ready = 1'b0;
      i_data       = 32'h1234_5678;
      i_data_valid = 1'b1;
      @(negedge i_clk);
      acc0 = acc_cnt;
      held = o_coeff;
      check("bp_first", 32'(held), 32'h0000_0A5A);
      for (int i = 0; i < 10; i++) begin
         @(negedge i_clk);
         check("bp_valid", 32'(o_coeff_valid), 32'd1);
         check("bp_hold", 32'(o_coeff), 32'h0000_0A5A);
         check("bp_ready", 32'(o_data_ready), 32'd0);
      end
      check("bp_no_accept", 32'(acc_cnt), 32'(acc0));
      i_data_valid = 1'b0;

      // Reset mid-frame after 40 coefficients.
      do_reset();
      i_data       = 32'h0BAD_0000;
      i_data_valid = 1'b1;
      g = 0;
      while (emit_cnt < 40 && g < 2000) begin
         bit got;
         @(negedge i_clk);
         got = o_data_ready;
         @(posedge i_clk);
         #1;
         if (got) i_data = i_data + 32'd1;
         i_coeff_ready = 1'($urandom_range(0, 1));
         g++;
      end
      check("mid_reached", 32'(emit_cnt >= 40), 32'd1);
      check("mid_no_last", 32'(last_cnt), 32'd0);
      do_reset();
      send(96, 32'h0300_0000, 1'b1);
      drain(1'b1);
      check("mid_count", 32'(emit_cnt), 32'd256);
      check("mid_last_at", 32'(last_at), 32'd256);

      // Two back-to-back frames.
      do_reset();
      send(192, 32'h5000_0000, 1'b1);
      drain(1'b1);
      @(negedge i_clk);
      check("b2b_count", 32'(emit_cnt), 32'd512);
      check("b2b_lasts", 32'(last_cnt), 32'd2);
      check("b2b_last_at", 32'(last_at), 32'd512);
      check("b2b_fill", 32'(dut.fill), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/unpack_gearbox.md
# unpack_gearbox

Width-reducing gearbox that splits a stream of INPUT_WIDTH-bit words (AXI-side 32-bit words) into OUTPUT_WIDTH-bit coefficients (12-bit Kyber coefficients), least-significant bit first. It is the inverse of the word-concatenation stage. It sits on the load path between the AXI input buffer and the polynomial/NTT memories. Both sides use valid/ready handshakes, and frames are delimited by a coefficient count.

## Interface
Parameters:
- INPUT_WIDTH, 32, width of input words
- OUTPUT_WIDTH, 12, width of output coefficients; must satisfy 1 ≤ OUTPUT_WIDTH ≤ INPUT_WIDTH
- FRAME_COEFFS, 256, coefficients per frame (one polynomial)

Ports:
- i_clk  in  1  clock; all logic on rising edge
- i_reset_n  in  1  reset, synchronous, active-low
- i_data  in  INPUT_WIDTH  input word
- i_data_valid  in  1  i_data is valid
- o_data_ready  out  1  block accepts i_data this cycle
- o_coeff  out  OUTPUT_WIDTH  output coefficient
- o_coeff_valid  out  1  o_coeff is valid
- i_coeff_ready  in  1  downstream accepts o_coeff
- o_coeff_last  out  1  o_coeff is the last coefficient of the frame

## Operation
- State:
  - bit buffer buf, BUF_W = INPUT_WIDTH + OUTPUT_WIDTH − 1 bits;
  - fill counter fill, 0..BUF_W;
  - coefficient counter cnt, 0..FRAME_COEFFS−1.
- o_data_ready = i_reset_n && (fill < OUTPUT_WIDTH). It depends only on registered state; there is no combinational path from i_coeff_ready.
- o_coeff_valid = (fill ≥ OUTPUT_WIDTH). Accept and emit are therefore mutually exclusive in any cycle.
- o_coeff = buf[OUTPUT_WIDTH−1:0].
- o_coeff_last = o_coeff_valid && (cnt == FRAME_COEFFS−1).
- Accept (i_data_valid && o_data_ready):
  - buf[fill +: INPUT_WIDTH] ← i_data;
  - fill ← fill + INPUT_WIDTH.
- Emit (o_coeff_valid && i_coeff_ready):
  - buf ← buf >> OUTPUT_WIDTH, zero-filling;
  - fill ← fill − OUTPUT_WIDTH;
  - cnt ← cnt + 1.
- Frame end (emit while o_coeff_last):
  - cnt ← 0;
  - fill ← 0, discarding residual bits;
  - buf ← 0.
  - For 32→12 with 256 coefficients (96 words), the residue is exactly 0.
- No handshake: all state holds.
- Bit order: bit 0 of the first word is bit 0 of the first coefficient. Words split across coefficients are concatenated LSB-first.

## Timing
- Reset values:
  - buf=0, fill=0, cnt=0;
  - o_coeff=0, o_coeff_valid=0, o_coeff_last=0;
  - o_data_ready=0 while i_reset_n is low, 1 in the first cycle after release.
- Latency: a word accepted at edge t produces o_coeff_valid high from cycle t+1.
- Steady-state throughput for 32→12: 8 coefficients per 3 words, at one transfer per cycle on either side. Example sequence: accept, 2 emits, accept, 3 emits, accept, 3 emits.
- o_coeff and o_coeff_last are stable while o_coeff_valid=1 and i_coeff_ready=0 (AXI-stream hold rule).
- i_data_valid while o_data_ready=0 is ignored. The upstream stage must hold the word.
- Reset mid-frame: all state clears on the next edge. Partial coefficients are lost and no o_coeff_last is produced.
- fill never exceeds BUF_W; cnt wraps only through the frame-end rule.

## Structure
- The shared package `kyber_pkg` holds:
  - KYBER_N=256, KYBER_Q_BITS=12, AXI_DATA_W=32;
  - the derived localparams BUF_W and FILL_W = $clog2(BUF_W+1).
- A single module is sufficient. The coefficient counter may be factored out as `frame_counter` (parameter FRAME_COEFFS; outputs o_last, o_count), which is reused by the concatenation stage.

## Test plan
- Reset, then idle → o_coeff_valid=0, o_data_ready=1, o_coeff=0.
- Words 0x76543210, 0xFEDCBA98, with downstream always ready → coefficients 0x210, 0x543, 0x876, 0xBA9, 0xEDC; then fill=4 and o_data_ready=1.
- 96 words of incrementing pattern with i_coeff_ready toggled randomly → exactly 256 coefficients matching a golden LSB-first model; o_coeff_last only on the 256th; fill=0 and cnt=0 afterwards.
- Backpressure: hold i_coeff_ready=0 for 10 cycles with o_coeff_valid=1 → o_coeff constant, o_data_ready=0, no word accepted.
- Reset asserted after 40 coefficients → next frame restarts at coefficient 0 from a fresh word; o_coeff_last after 256 more coefficients.
- Two back-to-back frames → o_coeff_last asserted exactly twice, with no lost or extra coefficients at the frame boundary.
